// File: rtl/mac_ip_encode_deadlock_reporter.sv
// Deadlock reporter for the mac_ip_encode dataflow monitor.
// Waits for the block flag to persist for a programmable number of cycles,
// snapshots the per-process stall vectors, offers the snapshot on a
// valid/ready channel, raises a sticky interrupt and keeps event and
// stall-duration counters.
module mac_ip_encode_deadlock_reporter #(
    parameter int NUM_PROC  = 10,
    parameter int PERSIST_W = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 enable,
    input  logic                 block_in,
    input  logic [NUM_PROC-1:0]  proc_idle_vec,
    input  logic [NUM_PROC-1:0]  proc_chan_block_vec,
    input  logic [NUM_PROC-1:0]  proc_axis_block_vec,
    input  logic [PERSIST_W-1:0] persist_thresh,
    input  logic                 clear,
    output logic                 report_valid,
    input  logic                 report_ready,
    output logic [NUM_PROC-1:0]  report_idle,
    output logic [NUM_PROC-1:0]  report_chan,
    output logic [NUM_PROC-1:0]  report_axis,
    output logic [PERSIST_W-1:0] stall_cycles,
    output logic [CNT_W-1:0]     event_count,
    output logic                 irq
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_REPORT = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [PERSIST_W-1:0] P_ONE = PERSIST_W'(1);
    localparam logic [CNT_W-1:0]     C_ONE = CNT_W'(1);

    state_t                state_q;
    logic [PERSIST_W-1:0]  cnt_q;
    logic                  report_valid_q;
    logic [NUM_PROC-1:0]   report_idle_q;
    logic [NUM_PROC-1:0]   report_chan_q;
    logic [NUM_PROC-1:0]   report_axis_q;
    logic [PERSIST_W-1:0]  stall_q;
    logic [PERSIST_W-1:0]  stall_d;
    logic [CNT_W-1:0]      event_q;
    logic [CNT_W-1:0]      event_d;
    logic                  irq_q;
    logic                  irq_d;

    logic [PERSIST_W-1:0]  thresh_eff;
    logic [PERSIST_W:0]    cnt_inc;
    logic                  arm_done;
    logic                  capture;

    // Effective threshold, persistence check (one extra bit so cnt+1 never wraps) and capture strobe
    always_comb begin
        thresh_eff = (persist_thresh == '0) ? P_ONE : persist_thresh;
        cnt_inc    = {1'b0, cnt_q} + {{PERSIST_W{1'b0}}, 1'b1};
        arm_done   = (cnt_inc >= {1'b0, thresh_eff});
        capture    = enable && block_in &&
                     (((state_q == S_IDLE) && (thresh_eff == P_ONE)) ||
                      ((state_q == S_ARM) && arm_done));
    end

    // Detection FSM with registered report channel; snapshot taken on capture
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            report_valid_q <= 1'b0;
            report_idle_q  <= '0;
            report_chan_q  <= '0;
            report_axis_q  <= '0;
        end else begin
            if (capture) begin
                state_q        <= S_REPORT;
                cnt_q          <= '0;
                report_valid_q <= 1'b1;
                report_idle_q  <= proc_idle_vec;
                report_chan_q  <= proc_chan_block_vec;
                report_axis_q  <= proc_axis_block_vec;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (enable && block_in) begin
                            state_q <= S_ARM;
                            cnt_q   <= P_ONE;
                        end
                    end
                    S_ARM: begin
                        // Any dropout restarts persistence from zero
                        if (!block_in || !enable) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc[PERSIST_W-1:0];
                        end
                    end
                    S_REPORT: begin
                        // enable is deliberately ignored until the snapshot is consumed
                        if (report_ready) begin
                            report_valid_q <= 1'b0;
                            state_q        <= block_in ? S_HOLD : S_IDLE;
                        end
                    end
                    S_HOLD: begin
                        // The same deadlock episode is reported only once
                        if (!block_in) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Next values for the sticky irq, saturating event counter and stall counter
    always_comb begin
        irq_d   = irq_q;
        event_d = event_q;
        if (capture) begin
            irq_d   = 1'b1;
            // A coincident clear is overridden: the count restarts at one
            event_d = clear ? C_ONE : ((event_q == '1) ? event_q : event_q + C_ONE);
        end else if (clear) begin
            irq_d   = 1'b0;
            event_d = '0;
        end
        if (block_in) begin
            stall_d = (stall_q == '1) ? stall_q : stall_q + P_ONE;
        end else begin
            stall_d = '0;
        end
    end

    // Counter and interrupt registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            irq_q   <= 1'b0;
            event_q <= '0;
            stall_q <= '0;
        end else begin
            irq_q   <= irq_d;
            event_q <= event_d;
            stall_q <= stall_d;
        end
    end

    assign report_valid = report_valid_q;
    assign report_idle  = report_idle_q;
    assign report_chan  = report_chan_q;
    assign report_axis  = report_axis_q;
    assign stall_cycles = stall_q;
    assign event_count  = event_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_mac_ip_encode_deadlock_reporter.sv
// Self-checking bench for mac_ip_encode_deadlock_reporter: directed scenarios
// with literal expectations, then randomized traffic, all compared every cycle
// against an episode-level model of the reporter.
module tb_mac_ip_encode_deadlock_reporter;

    localparam int NP = 10;

    logic           ap_clk = 1'b0;
    logic           ap_rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           block_in = 1'b0;
    logic [NP-1:0]  proc_idle_vec = '0;
    logic [NP-1:0]  proc_chan_block_vec = '0;
    logic [NP-1:0]  proc_axis_block_vec = '0;
    logic [15:0]    persist_thresh = 16'd4;
    logic           clear = 1'b0;
    logic           report_ready = 1'b0;

    logic           report_valid;
    logic [NP-1:0]  report_idle, report_chan, report_axis;
    logic [15:0]    stall_cycles;
    logic [15:0]    event_count;
    logic           irq;

    logic           v4, irq4;
    logic [NP-1:0]  ri4, rc4, ra4;
    logic [3:0]     stall4;
    logic [15:0]    ev4;

    int tests_run = 0;
    int tests_failed = 0;

    mac_ip_encode_deadlock_reporter #(.NUM_PROC(NP), .PERSIST_W(16), .CNT_W(16)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable), .block_in(block_in),
        .proc_idle_vec(proc_idle_vec), .proc_chan_block_vec(proc_chan_block_vec),
        .proc_axis_block_vec(proc_axis_block_vec), .persist_thresh(persist_thresh),
        .clear(clear), .report_valid(report_valid), .report_ready(report_ready),
        .report_idle(report_idle), .report_chan(report_chan), .report_axis(report_axis),
        .stall_cycles(stall_cycles), .event_count(event_count), .irq(irq)
    );

    // Narrow stall counter instance to reach saturation quickly
    mac_ip_encode_deadlock_reporter #(.NUM_PROC(NP), .PERSIST_W(4), .CNT_W(16)) dut4 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable), .block_in(block_in),
        .proc_idle_vec(proc_idle_vec), .proc_chan_block_vec(proc_chan_block_vec),
        .proc_axis_block_vec(proc_axis_block_vec), .persist_thresh(persist_thresh[3:0]),
        .clear(clear), .report_valid(v4), .report_ready(report_ready),
        .report_idle(ri4), .report_chan(rc4), .report_axis(ra4),
        .stall_cycles(stall4), .event_count(ev4), .irq(irq4)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic void chk(input string name, input longint act, input longint exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // pending: a snapshot is waiting for the consumer.
    // episode_done: the current block episode was already reported and consumed.
    // armed_run: consecutive enabled block cycles seen while free to detect.
    bit        m_pending, m_episode_done, m_irq;
    int        armed_run, m_events, m_stall16, m_stall4;
    bit [NP-1:0] m_idle, m_chan, m_axis;

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_pending = 0; m_episode_done = 0; m_irq = 0;
            armed_run = 0; m_events = 0; m_stall16 = 0; m_stall4 = 0;
            m_idle = '0; m_chan = '0; m_axis = '0;
        end else begin
            int  t;
            bit  free, cap;
            t    = (persist_thresh == 0) ? 1 : int'(persist_thresh);
            free = !m_pending && !m_episode_done;
            cap  = free && enable && block_in && (armed_run + 1 >= t);
            if (m_pending && report_ready) begin
                m_pending = 0;
                m_episode_done = block_in;
                $display("[TB] report consumed idle=0x%0h chan=0x%0h axis=0x%0h", m_idle, m_chan, m_axis);
            end else if (m_episode_done && !block_in) begin
                m_episode_done = 0;
            end
            if (cap) begin
                m_pending = 1;
                m_idle = proc_idle_vec; m_chan = proc_chan_block_vec; m_axis = proc_axis_block_vec;
                armed_run = 0;
            end else if (free && enable && block_in) begin
                armed_run++;
            end else begin
                armed_run = 0;
            end
            if (cap) begin
                m_irq = 1;
                m_events = clear ? 1 : ((m_events == 65535) ? 65535 : m_events + 1);
            end else if (clear) begin
                m_irq = 0;
                m_events = 0;
            end
            m_stall16 = block_in ? ((m_stall16 == 65535) ? 65535 : m_stall16 + 1) : 0;
            m_stall4  = block_in ? ((m_stall4 == 15) ? 15 : m_stall4 + 1) : 0;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge ap_clk) begin
        chk("report_valid", report_valid, m_pending);
        chk("irq", irq, m_irq);
        chk("event_count", event_count, m_events);
        chk("stall_cycles", stall_cycles, m_stall16);
        chk("report_idle", report_idle, m_idle);
        chk("report_chan", report_chan, m_chan);
        chk("report_axis", report_axis, m_axis);
        chk("w4_report_valid", v4, m_pending);
        chk("w4_stall_cycles", stall4, m_stall4);
    end

    task automatic step(input int n);
        repeat (n) @(posedge ap_clk);
        #2;
    endtask

    task automatic drain();
        block_in = 0; report_ready = 1; clear = 0; enable = 1;
        step(3);
        report_ready = 0;
    endtask

    int run_left;
    initial begin
        // Reset state
        #2;
        chk("rst_valid", report_valid, 0);
        chk("rst_irq", irq, 0);
        chk("rst_stall", stall_cycles, 0);
        step(2);
        ap_rst_n = 1;
        enable = 1;
        step(1);

        // 1: short block below threshold
        $display("[TB] test 1: sub-threshold block");
        persist_thresh = 4; block_in = 1;
        step(3);
        chk("t1_stall3", stall_cycles, 3);
        chk("t1_valid", report_valid, 0);
        block_in = 0;
        step(1);
        chk("t1_stall0", stall_cycles, 0);
        chk("t1_irq", irq, 0);
        chk("t1_events", event_count, 0);

        // 2: full report, hold, re-report
        $display("[TB] test 2: report and hold");
        proc_idle_vec = 10'h2F0; proc_chan_block_vec = 10'h10F; proc_axis_block_vec = 10'h00E;
        block_in = 1;
        step(3);
        chk("t2_valid_early", report_valid, 0);
        step(1);
        chk("t2_valid", report_valid, 1);
        chk("t2_irq", irq, 1);
        chk("t2_idle", report_idle, 10'h2F0);
        chk("t2_chan", report_chan, 10'h10F);
        chk("t2_axis", report_axis, 10'h00E);
        chk("t2_events", event_count, 1);
        proc_idle_vec = 10'h3FF; proc_chan_block_vec = 10'h000; proc_axis_block_vec = 10'h155;
        step(20);
        chk("t2_idle_stable", report_idle, 10'h2F0);
        chk("t2_valid_stable", report_valid, 1);
        report_ready = 1;
        step(1);
        chk("t2_valid_drop", report_valid, 0);
        report_ready = 0;
        step(8);
        chk("t2_hold_no_rpt", report_valid, 0);
        block_in = 0;
        step(1);
        block_in = 1;
        step(4);
        chk("t2_second", report_valid, 1);
        chk("t2_events2", event_count, 2);
        chk("t2_idle2", report_idle, 10'h3FF);
        drain();

        // 3: threshold 0 behaves as 1
        $display("[TB] test 3: zero threshold");
        persist_thresh = 0; block_in = 1;
        step(1);
        block_in = 0;
        chk("t3_valid", report_valid, 1);
        drain();

        // 4: clear vs capture
        $display("[TB] test 4: clear interaction");
        persist_thresh = 2; block_in = 1;
        step(1);
        clear = 1;
        step(1);
        clear = 0;
        chk("t4_irq", irq, 1);
        chk("t4_events", event_count, 1);
        step(1);
        clear = 1;
        step(1);
        clear = 0;
        chk("t4_irq_clr", irq, 0);
        chk("t4_events_clr", event_count, 0);
        chk("t4_valid_kept", report_valid, 1);
        drain();

        // 5: disabled detection and stall saturation
        $display("[TB] test 5: disabled, stall saturation");
        enable = 0; block_in = 1;
        step(100);
        chk("t5_stall100", stall_cycles, 100);
        chk("t5_stall4_sat", stall4, 15);
        chk("t5_valid", report_valid, 0);
        drain();

        // 6: asynchronous reset while a report is pending
        $display("[TB] test 6: async reset mid-report");
        persist_thresh = 3; block_in = 1;
        step(3);
        chk("t6_valid_pre", report_valid, 1);
        #1 ap_rst_n = 0;
        #1;
        chk("t6_valid_rst", report_valid, 0);
        chk("t6_irq_rst", irq, 0);
        chk("t6_events_rst", event_count, 0);
        chk("t6_idle_rst", report_idle, 0);
        chk("t6_stall_rst", stall_cycles, 0);
        block_in = 0;
        step(2);
        ap_rst_n = 1;
        step(1);
        block_in = 1;
        step(2);
        chk("t6_not_yet", report_valid, 0);
        step(1);
        chk("t6_after", report_valid, 1);
        drain();

        // Randomized traffic
        $display("[TB] random phase");
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                block_in = ~block_in;
                run_left = block_in ? $urandom_range(1, 9) : $urandom_range(1, 4);
                if (!block_in && ($urandom_range(0, 3) == 0))
                    persist_thresh = 16'($urandom_range(0, 6));
            end
            run_left--;
            enable       = ($urandom_range(0, 15) != 0);
            report_ready = ($urandom_range(0, 3) == 0);
            clear        = ($urandom_range(0, 39) == 0);
            proc_idle_vec       = NP'($urandom);
            proc_chan_block_vec = NP'($urandom);
            proc_axis_block_vec = NP'($urandom);
            step(1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mac_ip_encode_deadlock_reporter.md
Name: mac_ip_encode_deadlock_reporter

Overview:
- Consumer of the mac_ip_encode dataflow deadlock monitor's block flag and its per-process stall vectors.
- Requires the block condition to persist for a programmable number of cycles, then captures a snapshot of the process state.
- Presents the snapshot to host/debug logic through a valid/ready report channel, and raises a sticky interrupt.
- Keeps a saturating event counter and a live stall-duration counter.

Parameters:
- NUM_PROC, 10, number of dataflow processes observed (width of each state vector).
- PERSIST_W, 16, width of the persistence threshold and the stall-duration counter.
- CNT_W, 16, width of the event counter.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- enable  in  1  arms detection; when 0, no new capture starts.
- block_in  in  1  registered block flag from the deadlock monitor.
- proc_idle_vec  in  NUM_PROC  per-process idle.
- proc_chan_block_vec  in  NUM_PROC  per-process channel-blocked.
- proc_axis_block_vec  in  NUM_PROC  per-process AXIS-blocked.
- persist_thresh  in  PERSIST_W  required consecutive block cycles; 0 is treated as 1.
- clear  in  1  single-cycle pulse; clears irq and event_count.
- report_valid  out  1  snapshot available.
- report_ready  in  1  consumer accepts the snapshot.
- report_idle  out  NUM_PROC  captured proc_idle_vec.
- report_chan  out  NUM_PROC  captured proc_chan_block_vec.
- report_axis  out  NUM_PROC  captured proc_axis_block_vec.
- stall_cycles  out  PERSIST_W  live count of consecutive block_in cycles, saturating.
- event_count  out  CNT_W  number of captures since reset/clear, saturating.
- irq  out  1  sticky interrupt.

Behaviour:
- Reset (ap_rst_n=0, asynchronous): state IDLE. All outputs 0: report_valid, report_*, stall_cycles, event_count, irq. Internal persist counter 0.
- Reset asserted mid-report drops report_valid immediately; no handshake is completed.
- Effective threshold T = max(persist_thresh, 1). persist_thresh is sampled every cycle and must be held stable while in ARM.
- FSM states and transitions:
  - IDLE: if enable & block_in & T==1, capture -> REPORT. Else if enable & block_in, cnt<=1 -> ARM. Otherwise stay in IDLE.
  - ARM: if !block_in | !enable, cnt<=0 -> IDLE. Else if cnt+1 >= T, capture -> REPORT. Else cnt<=cnt+1.
  - REPORT: report_valid=1 and report_* held stable. On report_ready, go to HOLD if block_in=1 that cycle, else IDLE. enable is ignored in this state.
  - HOLD: the same deadlock is never reported twice. Stay until block_in=0, then -> IDLE.
- Capture:
  - report_* are registered from the input vectors in the capturing cycle.
  - event_count increments, saturating at all ones.
  - irq is set to 1.
- Latency: if block_in is high in cycles t..t+T-1 with enable=1 and the FSM is in IDLE at t:
  - snapshot is taken from cycle t+T-1 inputs;
  - report_valid=1 and irq=1 from cycle t+T.
- Handshake: transfer occurs on a cycle with report_valid & report_ready. report_valid deasserts the next cycle. report_ready while report_valid=0 has no effect. report_* keep their last value after transfer.
- stall_cycles:
  - each cycle: if block_in=1, stall_cycles <= sat(stall_cycles+1); else stall_cycles <= 0;
  - independent of enable and FSM state;
  - saturates at 2^PERSIST_W-1 with no wrap.
- clear:
  - sets irq<=0 and event_count<=0;
  - does not affect the FSM, the pending report or stall_cycles.
  - If clear and a capture coincide, the capture wins: irq=1, event_count=1.
- Any block_in dropout during ARM restarts the persistence count from zero.

Test Plan:
1. T=4, enable=1, block_in high for 3 cycles then low -> no report_valid, irq=0, event_count=0; stall_cycles reaches 3, then returns to 0.
2. T=4, block_in held high from cycle 10, proc_idle_vec=0x2F0, proc_chan_block_vec=0x10F, proc_axis_block_vec=0x00E, report_ready=0 -> report_valid=1 and irq=1 at cycle 14; report_idle=0x2F0, report_chan=0x10F, report_axis=0x00E; event_count=1. Hold ready low for 20 cycles -> outputs stable. Assert ready -> valid low next cycle; FSM stays in HOLD with no second report while block_in stays high. Drop block_in, then re-raise it for 4 cycles -> second report, event_count=2.
3. persist_thresh=0, block_in pulses high for 1 cycle at cycle 5 -> report_valid=1 at cycle 6.
4. clear pulsed in the same cycle as a capture -> irq=1, event_count=1. clear pulsed alone while report pending -> irq=0, event_count=0, report_valid stays 1.
5. enable=0 with block_in high for 100 cycles -> no report, stall_cycles=100. With PERSIST_W=4, block_in held high for 40 cycles -> stall_cycles saturates at 15.
6. ap_rst_n asserted asynchronously while report_valid=1, mid-cycle -> all outputs 0 immediately. After release with block_in low, FSM is in IDLE and the next T-cycle block produces a report.
